seg7_anim_engine: RTL

Parametrised animation engine for the 7-segment display path. It sits between the debounced one-shot button pulses and the per-frame segment lookup. It owns:
- animation selection and frame stepping;
- a saturating speed setting;
- pause, single-step and reverse modes;
- multi-digit scan with a per-digit frame offset.

It generalises the single-digit, fixed-width animation counter and adds multiplexed digits, direction control and stepping.

---
 rtl/seg7_anim_engine_if.sv | 36 +++
 rtl/seg7_anim_engine.sv | 116 +++++++++++
 2 files changed

// File: rtl/seg7_anim_engine_if.sv
// seg7_anim_engine_if: control pulses, frame limit and display outputs of the animation engine.
// master: drives the one-shot button pulses and frame_limit, observes animation/frame/scan outputs.
// slave : the engine itself.
interface seg7_anim_engine_if #(
  parameter int COUNTER_BIT = 25,
  parameter int ANI_BIT = 6,
  parameter int FRAME_BIT = 6,
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_BIT = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic ani_inc;
  logic ani_dec;
  logic speed_inc;
  logic speed_dec;
  logic pause_toggle;
  logic reverse_toggle;
  logic step;
  logic [FRAME_BIT-1:0] frame_limit;
  logic [ANI_BIT-1:0] animation;
  logic [FRAME_BIT-1:0] frame;
  logic [COUNTER_BIT-1:0] compare;
  logic tick;
  logic paused;
  logic reverse;
  logic [IDX_BIT-1:0] digit_idx;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [FRAME_BIT-1:0] digit_frame;
  modport master (
    output ani_inc, ani_dec, speed_inc, speed_dec, pause_toggle, reverse_toggle, step, frame_limit,
    input animation, frame, compare, tick, paused, reverse, digit_idx, digit_sel, digit_frame
  );
  modport slave (
    input ani_inc, ani_dec, speed_inc, speed_dec, pause_toggle, reverse_toggle, step, frame_limit,
    output animation, frame, compare, tick, paused, reverse, digit_idx, digit_sel, digit_frame
  );
endinterface

// File: rtl/seg7_anim_engine.sv
// seg7_anim_engine: animation select, frame stepping, speed, pause/step/reverse and multi-digit scan.
// Ports: clk, reset (sync, active-high), bus (slave modport): button pulses and frame_limit in;
// animation, frame, compare, tick, paused, reverse, digit_idx, digit_sel, digit_frame out.
module seg7_anim_engine #(
  parameter int COUNTER_BIT = 25,
  parameter int COMPARE_INIT = 10_000_000,
  parameter int COMPARE_MIN = 1_000_000,
  parameter int COMPARE_MAX = 19_000_000,
  parameter int COMPARE_STEP = 1_000_000,
  parameter int ANI_BIT = 6,
  parameter int ANI_MAX = 50,
  parameter int FRAME_BIT = 6,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_BIT = 14
) (
  input logic clk,
  input logic reset,
  seg7_anim_engine_if.slave bus
);
  localparam int IDX_BIT = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = COUNTER_BIT + 1;
  localparam int SW = FRAME_BIT + IDX_BIT + 1;
  localparam logic [CW-1:0] STEP_W = CW'(COMPARE_STEP);
  localparam logic [CW-1:0] MIN_W = CW'(COMPARE_MIN);
  localparam logic [CW-1:0] MAX_W = CW'(COMPARE_MAX);
  localparam logic [COUNTER_BIT-1:0] INIT_C = COUNTER_BIT'(COMPARE_INIT);
  localparam logic [COUNTER_BIT-1:0] STEP_C = COUNTER_BIT'(COMPARE_STEP);
  localparam logic [ANI_BIT-1:0] ANI_TOP = ANI_BIT'(ANI_MAX);
  localparam logic [IDX_BIT-1:0] IDX_TOP = IDX_BIT'(NUM_DIGITS - 1);

  logic [COUNTER_BIT-1:0] counter;
  logic [COUNTER_BIT-1:0] compare;
  logic [ANI_BIT-1:0] animation;
  logic [FRAME_BIT-1:0] frame;
  logic tick;
  logic paused;
  logic reverse;
  logic [SCAN_BIT-1:0] scan;
  logic [IDX_BIT-1:0] digit_idx;
  logic [NUM_DIGITS-1:0] digit_sel;

  logic ani_up;
  logic ani_dn;
  logic ani_chg;
  logic run_evt;
  logic evt;
  logic spd_up;
  logic spd_dn;
  logic [ANI_BIT-1:0] ani_nxt;
  logic [FRAME_BIT-1:0] frame_adv;
  logic [IDX_BIT-1:0] idx_nxt;
  logic [FRAME_BIT-1:0] frame_base;
  logic [SW-1:0] modulus;
  logic [SW-1:0] red;

  always_comb begin
    ani_up = bus.ani_inc & ~bus.ani_dec;
    ani_dn = bus.ani_dec & ~bus.ani_inc;
    ani_chg = ani_up | ani_dn;
    ani_nxt = ani_up ? ((animation == ANI_TOP) ? '0 : animation + 1'b1)
                     : ((animation == '0) ? ANI_TOP : animation - 1'b1);
    // counter+1 >= compare: lowering compare ends the running period at once
    run_evt = ~paused & (({1'b0, counter} + 1'b1) >= {1'b0, compare});
    evt = paused ? bus.step : run_evt;
    frame_adv = reverse ? (((frame == '0) || (frame > bus.frame_limit)) ? bus.frame_limit : frame - 1'b1)
                        : ((frame >= bus.frame_limit) ? '0 : frame + 1'b1);
    // speed limits evaluated one bit wider so compare+step cannot wrap
    spd_up = bus.speed_inc & ~bus.speed_dec & (({1'b0, compare} + STEP_W) <= MAX_W);
    spd_dn = bus.speed_dec & ~bus.speed_inc & ({1'b0, compare} >= (MIN_W + STEP_W));
    idx_nxt = (&scan) ? ((digit_idx == IDX_TOP) ? '0 : digit_idx + 1'b1) : digit_idx;
  end

  // (frame + digit_idx) mod (frame_limit+1); sum < NUM_DIGITS*(limit+1) so NUM_DIGITS-1 subtractions suffice
  always_comb begin
    frame_base = (frame > bus.frame_limit) ? '0 : frame;
    modulus = SW'(bus.frame_limit) + 1'b1;
    red = SW'(frame_base) + SW'(digit_idx);
    for (int i = 0; i < NUM_DIGITS - 1; i++) red = (red >= modulus) ? red - modulus : red;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      compare <= INIT_C;
      animation <= '0;
      frame <= '0;
      tick <= 1'b0;
      paused <= 1'b0;
      reverse <= 1'b0;
      scan <= '0;
      digit_idx <= '0;
      digit_sel <= NUM_DIGITS'(1);
    end else begin
      counter <= ani_chg ? '0 : paused ? counter : run_evt ? '0 : counter + 1'b1;
      animation <= ani_chg ? ani_nxt : animation;
      frame <= ani_chg ? '0 : evt ? frame_adv : frame;
      tick <= evt & ~ani_chg;
      compare <= spd_up ? compare + STEP_C : spd_dn ? compare - STEP_C : compare;
      paused <= paused ^ bus.pause_toggle;
      reverse <= reverse ^ bus.reverse_toggle;
      scan <= scan + 1'b1;
      digit_idx <= idx_nxt;
      digit_sel <= NUM_DIGITS'(1) << idx_nxt;
    end
  end

  assign bus.animation = animation;
  assign bus.frame = frame;
  assign bus.compare = compare;
  assign bus.tick = tick;
  assign bus.paused = paused;
  assign bus.reverse = reverse;
  assign bus.digit_idx = digit_idx;
  assign bus.digit_sel = digit_sel;
  assign bus.digit_frame = red[FRAME_BIT-1:0];
endmodule
